// File: rtl/acc_dump_decim.sv
// Accumulate-and-dump decimator: averages frames of 2^k valid samples into one
// rounded, saturated signed mean, with a shift_en strobe for the downstream delay line.
//
// state | meaning
// IDLE  | accumulator and counters cleared, waiting for enable
// ACC   | accumulating valid samples of the current frame

module acc_dump_decim #(
    parameter int DW        = 16,
    parameter int MAX_LOG2N = 4,
    parameter int LEN       = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic [$clog2(MAX_LOG2N+1)-1:0]   log2_n,
    input  logic signed [DW-1:0]             d_in,
    input  logic                             d_in_val,
    output logic signed [DW-1:0]             d_out,
    output logic                             d_out_val,
    output logic                             shift_en,
    output logic                             primed
);

    localparam int KW  = $clog2(MAX_LOG2N + 1);
    localparam int AW  = DW + MAX_LOG2N + 1;
    localparam int CW  = MAX_LOG2N + 1;
    localparam int DCW = $clog2(LEN + 1);

    localparam logic signed [AW:0] SAT_HI = (AW+1)'(2**(DW-1) - 1);
    localparam logic signed [AW:0] SAT_LO = -(AW+1)'(2**(DW-1));

    typedef enum logic {IDLE, ACC} state_t;

    state_t                state, state_nxt;
    logic signed [AW-1:0]  acc, acc_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [KW-1:0]         k_lat, k_nxt;
    logic [DCW-1:0]        dump_cnt;
    logic                  dump;

    logic [KW-1:0]         k_req;
    logic signed [AW-1:0]  din_ext;
    logic signed [AW-1:0]  sum;
    logic [CW-1:0]         frame_last;
    logic signed [AW:0]    rnd;
    logic signed [AW:0]    rsum;
    logic signed [AW:0]    scaled;
    logic signed [DW-1:0]  d_sat;

    assign k_req      = (log2_n > KW'(MAX_LOG2N)) ? KW'(MAX_LOG2N) : log2_n;
    assign din_ext    = AW'(d_in);
    assign sum        = acc + din_ext;
    assign frame_last = (CW'(1) << k_lat) - CW'(1);

    // Round half up: add half an LSB of the result before the arithmetic shift.
    assign rnd    = (k_lat == '0) ? '0 : ((AW+1)'(1) << (k_lat - KW'(1)));
    assign rsum   = (AW+1)'(sum) + rnd;
    assign scaled = rsum >>> k_lat;

    always_comb begin
        d_sat = DW'(scaled);
        if (scaled > SAT_HI)
            d_sat = DW'(SAT_HI);
        else if (scaled < SAT_LO)
            d_sat = DW'(SAT_LO);
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        k_nxt     = k_lat;
        dump      = 1'b0;
        case (state)
            IDLE: begin
                acc_nxt = '0;
                cnt_nxt = '0;
                if (enable) begin
                    state_nxt = ACC;
                    k_nxt     = k_req;
                end
            end
            ACC: begin
                if (!enable) begin
                    // Partial frame and any sample arriving this cycle are dropped.
                    state_nxt = IDLE;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                end else if (d_in_val) begin
                    if (cnt == frame_last) begin
                        dump    = 1'b1;
                        acc_nxt = '0;
                        cnt_nxt = '0;
                        k_nxt   = k_req;
                    end else begin
                        acc_nxt = sum;
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            k_lat     <= '0;
            d_out     <= '0;
            d_out_val <= 1'b0;
            shift_en  <= 1'b0;
            dump_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            k_lat     <= k_nxt;
            d_out_val <= dump;
            shift_en  <= dump;
            if (dump)
                d_out <= d_sat;
            if (state_nxt == IDLE)
                dump_cnt <= '0;
            else if (dump && dump_cnt != DCW'(LEN))
                dump_cnt <= dump_cnt + DCW'(1);
        end
    end

    assign primed = (dump_cnt == DCW'(LEN));

endmodule

// File: tb/tb_acc_dump_decim.sv
// Directed bench for acc_dump_decim: inputs change just after the falling edge,
// outputs are sampled on the falling edge after each rising edge.

module tb_acc_dump_decim;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic [2:0]         log2_n;
    logic signed [15:0] d_in;
    logic               d_in_val;
    logic signed [15:0] d_out;
    logic               d_out_val;
    logic               shift_en;
    logic               primed;

    int n_cmp = 0;
    int n_bad = 0;

    acc_dump_decim #(.DW(16), .MAX_LOG2N(4), .LEN(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .log2_n    (log2_n),
        .d_in      (d_in),
        .d_in_val  (d_in_val),
        .d_out     (d_out),
        .d_out_val (d_out_val),
        .shift_en  (shift_en),
        .primed    (primed)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic signed [15:0] x);
        d_in = x; d_in_val = 1'b1;
        tick();
        d_in_val = 1'b0;
    endtask

    task automatic start(input logic [2:0] k);
        log2_n = k; enable = 1'b1; d_in_val = 1'b0;
        tick();
    endtask

    task automatic stop();
        enable = 1'b0; d_in_val = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; log2_n = 3'd0; d_in = '0; d_in_val = 1'b0;
        tick(); tick();
        n_cmp++; if (d_out !== 16'sd0) begin n_bad++; $display("FAIL reset_d_out got %0d want 0", d_out); end
        n_cmp++; if (d_out_val !== 1'b0) begin n_bad++; $display("FAIL reset_d_out_val got %b want 0", d_out_val); end
        n_cmp++; if (shift_en !== 1'b0) begin n_bad++; $display("FAIL reset_shift_en got %b want 0", shift_en); end
        n_cmp++; if (primed !== 1'b0) begin n_bad++; $display("FAIL reset_primed got %b want 0", primed); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_k2_pos();
        start(3'd2);
        send(16'sd1); send(16'sd2); send(16'sd3);
        n_cmp++; if (d_out_val !== 1'b0) begin n_bad++; $display("FAIL k2_early_pulse got %b want 0", d_out_val); end
        send(16'sd4);
        n_cmp++; if (d_out !== 16'sd3) begin n_bad++; $display("FAIL k2_pos_d_out got %0d want 3", d_out); end
        n_cmp++; if (d_out_val !== 1'b1) begin n_bad++; $display("FAIL k2_pos_val got %b want 1", d_out_val); end
        n_cmp++; if (shift_en !== 1'b1) begin n_bad++; $display("FAIL k2_pos_shift_en got %b want 1", shift_en); end
        tick();
        n_cmp++; if (d_out_val !== 1'b0 || shift_en !== 1'b0) begin n_bad++; $display("FAIL k2_pulse_width got val=%b shift=%b want 0/0", d_out_val, shift_en); end
        n_cmp++; if (d_out !== 16'sd3) begin n_bad++; $display("FAIL k2_hold got %0d want 3", d_out); end
    endtask

    task automatic test_k2_neg();
        send(-16'sd1); send(-16'sd2); send(-16'sd2); send(-16'sd1);
        n_cmp++; if (d_out !== -16'sd1 || d_out_val !== 1'b1) begin n_bad++; $display("FAIL k2_neg_a got %0d/%b want -1/1", d_out, d_out_val); end
        for (int i = 0; i < 4; i++) send(-16'sd3);
        n_cmp++; if (d_out !== -16'sd3 || d_out_val !== 1'b1) begin n_bad++; $display("FAIL k2_neg_b got %0d/%b want -3/1", d_out, d_out_val); end
        n_cmp++; if (primed !== 1'b0) begin n_bad++; $display("FAIL k2_primed got %b want 0", primed); end
    endtask

    task automatic test_k4_sat();
        int pulses;
        logic signed [15:0] got [2];
        pulses = 0;
        stop();
        start(3'd4);
        for (int i = 0; i < 32; i++) begin
            send(i < 16 ? 16'sd32767 : -16'sd32768);
            if (d_out_val) begin
                if (pulses < 2) got[pulses] = d_out;
                pulses++;
            end
            tick();
            if (d_out_val) pulses++;
        end
        n_cmp++; if (pulses !== 2) begin n_bad++; $display("FAIL k4_pulses got %0d want 2", pulses); end
        n_cmp++; if (got[0] !== 16'sd32767) begin n_bad++; $display("FAIL k4_max got %0d want 32767", got[0]); end
        n_cmp++; if (got[1] !== -16'sd32768) begin n_bad++; $display("FAIL k4_min got %0d want -32768", got[1]); end
    endtask

    task automatic test_k0_primed();
        stop();
        start(3'd0);
        send(16'sd5);
        n_cmp++; if (d_out !== 16'sd5 || d_out_val !== 1'b1) begin n_bad++; $display("FAIL k0_a got %0d/%b want 5/1", d_out, d_out_val); end
        send(-16'sd7);
        n_cmp++; if (d_out !== -16'sd7 || d_out_val !== 1'b1) begin n_bad++; $display("FAIL k0_b got %0d/%b want -7/1", d_out, d_out_val); end
        send(16'sd100);
        n_cmp++; if (d_out !== 16'sd100 || shift_en !== 1'b1) begin n_bad++; $display("FAIL k0_c got %0d/%b want 100/1", d_out, shift_en); end
        for (int i = 1; i <= 4; i++) send(16'(i));
        n_cmp++; if (primed !== 1'b0) begin n_bad++; $display("FAIL primed_7th got %b want 0", primed); end
        send(16'sd9);
        n_cmp++; if (primed !== 1'b1 || d_out !== 16'sd9) begin n_bad++; $display("FAIL primed_8th got %b/%0d want 1/9", primed, d_out); end
    endtask

    task automatic test_clamp();
        int pulses;
        pulses = 0;
        stop();
        start(3'd7);
        for (int i = 0; i < 15; i++) begin
            send(16'sd2);
            if (d_out_val) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL clamp_early got %0d pulses want 0", pulses); end
        send(16'sd2);
        n_cmp++; if (d_out !== 16'sd2 || d_out_val !== 1'b1) begin n_bad++; $display("FAIL clamp_dump got %0d/%b want 2/1", d_out, d_out_val); end
    endtask

    task automatic test_abort();
        int pulses;
        pulses = 0;
        stop();
        start(3'd0);
        for (int i = 0; i < 8; i++) send(16'sd9);
        n_cmp++; if (primed !== 1'b1) begin n_bad++; $display("FAIL abort_pre_primed got %b want 1", primed); end
        stop();
        n_cmp++; if (primed !== 1'b0) begin n_bad++; $display("FAIL abort_idle_primed got %b want 0", primed); end
        n_cmp++; if (d_out !== 16'sd9) begin n_bad++; $display("FAIL abort_hold got %0d want 9", d_out); end
        start(3'd3);
        for (int i = 0; i < 5; i++) send(16'sd8);
        enable = 1'b0; d_in = 16'sd8; d_in_val = 1'b1;
        tick();
        d_in_val = 1'b0;
        n_cmp++; if (d_out_val !== 1'b0) begin n_bad++; $display("FAIL abort_drop got %b want 0", d_out_val); end
        start(3'd3);
        for (int i = 0; i < 7; i++) begin
            send(16'sd8);
            if (d_out_val) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL abort_partial got %0d pulses want 0", pulses); end
        send(16'sd8);
        n_cmp++; if (d_out !== 16'sd8 || d_out_val !== 1'b1) begin n_bad++; $display("FAIL abort_new got %0d/%b want 8/1", d_out, d_out_val); end
    endtask

    task automatic test_k_change();
        stop();
        start(3'd2);
        send(16'sd10); send(16'sd20);
        log2_n = 3'd1;
        send(16'sd30);
        n_cmp++; if (d_out_val !== 1'b0) begin n_bad++; $display("FAIL kchg_early got %b want 0", d_out_val); end
        send(16'sd40);
        n_cmp++; if (d_out !== 16'sd25 || d_out_val !== 1'b1) begin n_bad++; $display("FAIL kchg_old got %0d/%b want 25/1", d_out, d_out_val); end
        send(16'sd7);
        n_cmp++; if (d_out_val !== 1'b0) begin n_bad++; $display("FAIL kchg_new_early got %b want 0", d_out_val); end
        send(16'sd8);
        n_cmp++; if (d_out !== 16'sd8 || d_out_val !== 1'b1) begin n_bad++; $display("FAIL kchg_new got %0d/%b want 8/1", d_out, d_out_val); end
    endtask

    task automatic test_rst_mid();
        send(16'sd1);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (d_out !== 16'sd0 || primed !== 1'b0 || d_out_val !== 1'b0) begin n_bad++; $display("FAIL rst_async got %0d/%b/%b want 0/0/0", d_out, primed, d_out_val); end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (d_out_val !== 1'b0 || d_out !== 16'sd0) begin n_bad++; $display("FAIL rst_release got %b/%0d want 0/0", d_out_val, d_out); end
        send(16'sd3);
        n_cmp++; if (d_out_val !== 1'b0) begin n_bad++; $display("FAIL rst_no_partial got %b want 0", d_out_val); end
        send(16'sd5);
        n_cmp++; if (d_out !== 16'sd4 || d_out_val !== 1'b1) begin n_bad++; $display("FAIL rst_new_frame got %0d/%b want 4/1", d_out, d_out_val); end
    endtask

    initial begin
        test_reset();
        test_k2_pos();
        test_k2_neg();
        test_k4_sat();
        test_k0_primed();
        test_clamp();
        test_abort();
        test_k_change();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
